// File: rtl/ilv_pkg.sv
// Shared types for the ping-pong block interleaver: mode encoding, bank states and block size.
package ilv_pkg;

    typedef enum logic {
        MODE_ILV   = 1'b0,
        MODE_DEILV = 1'b1
    } ilv_mode_e;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_st_e;

    localparam int ILV_ROWS_DEF = 4;
    localparam int ILV_COLS_DEF = 7;

    function automatic int ilv_n(input int rows, input int cols);
        return rows * cols;
    endfunction

endpackage

// File: rtl/ilv_addr_gen.sv
// Row/column counter pair walking a ROWS x COLS matrix row- or column-major; addr = row*COLS+col.
// Zero latency from counters to addr; advances only on step, wraps to 0 at the final position.
module ilv_addr_gen #(
    parameter int ROWS = 4,
    parameter int COLS = 7,
    parameter int AW   = $clog2(ROWS * COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          col_major,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          row_end, col_end;

    always_comb begin
        row_end = (row_q == ROW_MAX);
        col_end = (col_q == COL_MAX);
        row_d   = row_q;
        col_d   = col_q;
        if (step) begin
            if (col_major) begin
                row_d = row_end ? '0 : row_q + 1'b1;
                if (row_end) col_d = col_end ? '0 : col_q + 1'b1;
            end else begin
                col_d = col_end ? '0 : col_q + 1'b1;
                if (col_end) row_d = row_end ? '0 : row_q + 1'b1;
            end
        end
    end

    assign last = row_end && col_end;
    assign addr = AW'(row_q) * AW'(COLS) + AW'(col_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/block_interleaver.sv
// Ping-pong ROWS x COLS block (de)interleaver; first output one edge after a bank becomes FULL.
// Valid/ready both sides; input stalls only when both banks hold complete or draining blocks.
module block_interleaver
    import ilv_pkg::*;
#(
    parameter int ROWS = ILV_ROWS_DEF,
    parameter int COLS = ILV_COLS_DEF,
    parameter int W    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last
);

    localparam int N  = ilv_n(ROWS, COLS);
    localparam int AW = $clog2(N);

    logic [W-1:0] mem_q [2][N];

    bank_st_e  st_q   [2];
    bank_st_e  st_d   [2];
    ilv_mode_e mode_q [2];
    ilv_mode_e mode_d [2];

    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [W-1:0]  out_data_q, out_data_d;

    logic          wr_en, rd_en, rd_avail;
    logic          wr_last, rd_last;
    logic [AW-1:0] wr_addr, rd_addr;
    ilv_mode_e     wr_mode;

    // Deinterleave writes column-major and reads row-major, so one counter type serves both modes.
    ilv_addr_gen #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) u_wr_addr (
        .clk       (clk),
        .rst       (rst),
        .step      (wr_en),
        .col_major (wr_mode == MODE_DEILV),
        .addr      (wr_addr),
        .last      (wr_last)
    );

    ilv_addr_gen #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) u_rd_addr (
        .clk       (clk),
        .rst       (rst),
        .step      (rd_en),
        .col_major (mode_q[rd_bank_q] == MODE_ILV),
        .addr      (rd_addr),
        .last      (rd_last)
    );

    always_comb begin
        wr_en    = in_valid && in_ready_q;
        wr_mode  = (st_q[wr_bank_q] == BANK_EMPTY) ? ilv_mode_e'(mode) : mode_q[wr_bank_q];
        rd_avail = (st_q[rd_bank_q] == BANK_FULL) || (st_q[rd_bank_q] == BANK_DRAINING);
        rd_en    = rd_avail && (!out_valid_q || out_ready);

        st_d        = st_q;
        mode_d      = mode_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        if (wr_en) begin
            if (st_q[wr_bank_q] == BANK_EMPTY) begin
                st_d[wr_bank_q]   = BANK_FILLING;
                mode_d[wr_bank_q] = wr_mode;
            end
            if (wr_last) begin
                st_d[wr_bank_q] = BANK_FULL;
                wr_bank_d       = ~wr_bank_q;
            end
        end

        if (rd_en) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rd_bank_q][rd_addr];
            out_last_d  = rd_last;
            if (rd_last) begin
                st_d[rd_bank_q] = BANK_EMPTY;
                rd_bank_d       = ~rd_bank_q;
            end else begin
                st_d[rd_bank_q] = BANK_DRAINING;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        in_ready_d = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (st_d[i] == BANK_EMPTY || st_d[i] == BANK_FILLING) in_ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_bank_q][wr_addr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]   <= BANK_EMPTY;
                mode_q[i] <= MODE_ILV;
            end
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            st_q        <= st_d;
            mode_q      <= mode_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_block_interleaver.sv
// Directed bench: interleave, chained deinterleave, backpressure, W=1 random stall, reset, mode switch.
module tb_block_interleaver;

    logic       clk, rst, mode, in_valid, in_ready, out_valid, out_last, out_rdy, ilv_out_ready;
    logic [7:0] in_data, out_data;
    logic       d_in_valid, d_in_ready, d_out_valid, d_out_last, d_out_ready, d_mode;
    logic [7:0] d_out_data;
    logic       b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_last;
    logic [0:0] b_in_data, b_out_data;

    assign ilv_out_ready = out_rdy & d_in_ready;
    assign d_in_valid    = out_valid & out_rdy;
    assign d_out_ready   = 1'b1;
    assign d_mode        = 1'b1;
    assign b_mode        = 1'b0;

    block_interleaver #(.ROWS(4), .COLS(7), .W(8)) u_ilv (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(ilv_out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    block_interleaver #(.ROWS(4), .COLS(7), .W(8)) u_dei (
        .clk(clk), .rst(rst), .mode(d_mode), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(out_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_data(d_out_data), .out_last(d_out_last)
    );

    block_interleaver #(.ROWS(4), .COLS(7), .W(1)) u_bit (
        .clk(clk), .rst(rst), .mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(out_rdy),
        .out_data(b_out_data), .out_last(b_out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int perm_ilv [28] = '{0, 7, 14, 21, 1, 8, 15, 22, 2, 9, 16, 23, 3, 10,
                          17, 24, 4, 11, 18, 25, 5, 12, 19, 26, 6, 13, 20, 27};
    int perm_dei [28] = '{0, 4, 8, 12, 16, 20, 24, 1, 5, 9, 13, 17, 21, 25,
                          2, 6, 10, 14, 18, 22, 26, 3, 7, 11, 15, 19, 23, 27};
    logic [27:0] bit_stim = 28'b0011111000011110110111100101;
    logic [27:0] bit_exp  = 28'b0011000110101010110111101111;

    int         n_checks, n_errors, cyc, n_acc, first_vld, last_acc;
    bit         sel_bit, chk_stable, rnd_rdy, prev_stall, prev_last;
    logic [7:0] prev_dat;
    logic [7:0] in_q [$];
    logic [7:0] cap_d [$];
    bit         cap_l [$];
    logic [7:0] dcap [$];
    bit         dcap_l [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        in_q.delete(); cap_d.delete(); cap_l.delete(); dcap.delete(); dcap_l.delete();
        n_acc = 0; first_vld = -1; last_acc = -1; prev_stall = 0;
    endtask

    task automatic tick(output bit acc);
        logic       ov, ordy, ol, iv, ir;
        logic [7:0] od;
        @(negedge clk);
        if (sel_bit) begin
            ov = b_out_valid; ordy = out_rdy; od = {7'b0, b_out_data}; ol = b_out_last;
            iv = b_in_valid;  ir = b_in_ready;
        end else begin
            ov = out_valid; ordy = ilv_out_ready; od = out_data; ol = out_last;
            iv = in_valid;  ir = in_ready;
        end
        if (chk_stable && prev_stall)
            check($sformatf("stall hold {v,l,d} cyc %0d", cyc), 32'({ov, ol, od}),
                  32'({1'b1, prev_last, prev_dat}));
        prev_stall = ov && !ordy;
        prev_dat   = od;
        prev_last  = ol;
        if (ov && first_vld < 0) first_vld = cyc;
        if (ov && ordy) begin cap_d.push_back(od); cap_l.push_back(ol); end
        if (d_out_valid) begin dcap.push_back(d_out_data); dcap_l.push_back(d_out_last); end
        acc = iv && ir;
        if (acc) last_acc = cyc;
        @(posedge clk);
        #1;
        cyc++;
        if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        bit acc;
        if (sel_bit) begin
            b_in_valid = (in_q.size() > 0);
            if (in_q.size() > 0) b_in_data = in_q[0][0];
        end else begin
            in_valid = (in_q.size() > 0);
            if (in_q.size() > 0) in_data = in_q[0];
        end
        tick(acc);
        if (acc) begin
            void'(in_q.pop_front());
            n_acc++;
        end
        in_valid   = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic run(input int max_cyc, input int want_out, input int want_acc,
                       input int want_dout, input string tag);
        int k = 0;
        while ((cap_d.size() < want_out || n_acc < want_acc || dcap.size() < want_dout)
               && k < max_cyc) begin
            step();
            k++;
        end
        check({tag, " completes in budget"},
              32'(cap_d.size() >= want_out && n_acc >= want_acc && dcap.size() >= want_dout), 1);
    endtask

    initial begin
        bit acc;
        n_checks = 0; n_errors = 0; cyc = 0;
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_rdy = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0;
        sel_bit = 0; chk_stable = 0; rnd_rdy = 0; prev_dat = '0; prev_last = 0;
        clear();

        // reset values and in_ready rising on the first edge out of reset
        #3;
        check("rst in_ready", 32'(in_ready), 0);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst out_last", 32'(out_last), 0);
        check("rst out_data", 32'(out_data), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("in_ready before first edge", 32'(in_ready), 0);
        tick(acc);
        check("in_ready after first edge", 32'(in_ready), 1);

        // interleave 0..27, chained deinterleaver restores order
        clear();
        for (int i = 0; i < 28; i++) in_q.push_back(8'(i));
        mode = 1'b0; out_rdy = 1'b1;
        run(300, 28, 28, 28, "t1");
        for (int j = 0; j < 28 && j < cap_d.size(); j++) begin
            check($sformatf("t1 data[%0d]", j), 32'(cap_d[j]), 32'(perm_ilv[j]));
            check($sformatf("t1 last[%0d]", j), 32'(cap_l[j]), (j == 27) ? 32'd1 : 32'd0);
        end
        check("t1 first out_valid latency", 32'(first_vld - last_acc), 2);
        for (int j = 0; j < 28 && j < dcap.size(); j++)
            check($sformatf("t1 deinterleaved[%0d]", j), 32'(dcap[j]), 32'(j));
        if (dcap_l.size() >= 28) check("t1 deinterleaved last", 32'(dcap_l[27]), 1);

        // three blocks with the output blocked, then drain
        clear();
        out_rdy = 1'b0;
        for (int i = 0; i < 84; i++) in_q.push_back(8'(i));
        run(150, 0, 56, 0, "t2 fill");
        check("t2 in_ready after 56th", 32'(in_ready), 0);
        repeat (10) step();
        check("t2 accepted while blocked", 32'(n_acc), 56);
        out_rdy = 1'b1;
        run(400, 84, 84, 0, "t2 drain");
        check("t2 output count", 32'(cap_d.size()), 84);
        for (int j = 0; j < 84 && j < cap_d.size(); j++)
            check($sformatf("t2 data[%0d]", j), 32'(cap_d[j]), 32'((j / 28) * 28 + perm_ilv[j % 28]));

        // W=1 bit stream with random output stalls
        clear();
        sel_bit = 1; chk_stable = 1; rnd_rdy = 1;
        for (int i = 0; i < 28; i++) in_q.push_back({7'b0, bit_stim[27 - i]});
        run(400, 28, 28, 0, "t3");
        repeat (20) step();
        rnd_rdy = 0; chk_stable = 0; out_rdy = 1'b1; sel_bit = 0;
        check("t3 output count", 32'(cap_d.size()), 28);
        for (int j = 0; j < 28 && j < cap_d.size(); j++)
            check($sformatf("t3 bit[%0d]", j), 32'(cap_d[j]), 32'(bit_exp[27 - j]));

        // reset with one block pending and 10 symbols of the next
        clear();
        out_rdy = 1'b0;
        for (int i = 0; i < 38; i++) in_q.push_back(8'(i));
        run(200, 0, 38, 0, "t4 fill");
        check("t4 out_valid before reset", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("t4 rst out_valid", 32'(out_valid), 0);
        check("t4 rst in_ready", 32'(in_ready), 0);
        check("t4 rst out_last", 32'(out_last), 0);
        check("t4 rst out_data", 32'(out_data), 0);
        #2;
        rst = 1'b0;
        tick(acc);
        check("t4 in_ready after reset", 32'(in_ready), 1);
        clear();
        out_rdy = 1'b1;
        for (int i = 0; i < 28; i++) in_q.push_back(8'(50 + i));
        run(200, 28, 28, 0, "t4 fresh");
        for (int j = 0; j < 28 && j < cap_d.size(); j++)
            check($sformatf("t4 data[%0d]", j), 32'(cap_d[j]), 32'(50 + perm_ilv[j]));

        // mode flipped at symbol 5 of block 1 only affects block 2
        clear();
        mode = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < 56; i++) in_q.push_back(8'(i));
        run(100, 0, 5, 0, "t5 head");
        mode = 1'b1;
        run(400, 56, 56, 0, "t5");
        for (int j = 0; j < 56 && j < cap_d.size(); j++)
            check($sformatf("t5 data[%0d]", j), 32'(cap_d[j]),
                  (j < 28) ? 32'(perm_ilv[j]) : 32'(28 + perm_dei[j - 28]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
